// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming 3x3 convolution over a raster-order frame.
// Two line buffers feed a 3x3 window; a 2-stage multiply / sum-shift-saturate pipeline.
module conv3x3_stream #(
    parameter int row_depth    = 10,
    parameter int column_depth = 10,
    parameter int D_BITS       = 8,
    parameter int K_BITS       = 8
) (
    input  logic              i_clk,
    input  logic              reset,
    input  logic              i_drdy,
    input  logic [D_BITS-1:0] i_data,
    input  logic              i_coef_we,
    input  logic [3:0]        i_coef_addr,
    input  logic [K_BITS-1:0] i_coef_data,
    input  logic [4:0]        i_shift,
    output logic              o_dvalid,
    output logic [D_BITS-1:0] o_data,
    output logic              o_frame_done
);

    localparam int CW = $clog2(column_depth);
    localparam int RW = $clog2(row_depth);
    localparam int PW = D_BITS + K_BITS + 1;
    localparam int SW = D_BITS + K_BITS + 5;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_last;
    logic          row_last;
    logic          win_ok;

    logic [D_BITS-1:0] lb0 [column_depth];
    logic [D_BITS-1:0] lb1 [column_depth];
    logic [D_BITS-1:0] up1;
    logic [D_BITS-1:0] up2;
    logic [D_BITS-1:0] ca [3];
    logic [D_BITS-1:0] cb [3];
    logic [D_BITS-1:0] win [9];

    logic signed [K_BITS-1:0] coef [9];
    logic signed [PW-1:0]     prod_c [9];
    logic signed [PW-1:0]     prod [9];
    logic [4:0]               s1_shift;
    logic                     s1_valid;
    logic                     s1_last;

    logic signed [SW-1:0] acc;
    logic signed [SW-1:0] shd;
    logic [D_BITS-1:0]    sat;

    assign col_last = (col == CW'(column_depth - 1));
    assign row_last = (row == RW'(row_depth - 1));
    assign win_ok   = (row >= RW'(2)) && (col >= CW'(2));
    assign up1      = lb0[col];
    assign up2      = lb1[col];

    // raster position of the next accepted pixel
    always_ff @(posedge i_clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (i_drdy) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // line buffers and the two older window columns (contents survive reset)
    always_ff @(posedge i_clk) begin
        if (!reset && i_drdy) begin
            lb1[col] <= up1;
            lb0[col] <= i_data;
            for (int k = 0; k < 3; k++) begin
                ca[k] <= cb[k];
            end
            cb[0] <= up2;
            cb[1] <= up1;
            cb[2] <= i_data;
        end
    end

    // window view: oldest column, previous column, column arriving now
    always_comb begin
        win[0] = ca[0];
        win[1] = cb[0];
        win[2] = up2;
        win[3] = ca[1];
        win[4] = cb[1];
        win[5] = up1;
        win[6] = ca[2];
        win[7] = cb[2];
        win[8] = i_data;
    end

    // kernel registers, identity after reset
    always_ff @(posedge i_clk) begin
        if (reset) begin
            for (int k = 0; k < 9; k++) begin
                coef[k] <= K_BITS'(k == 4 ? 1 : 0);
            end
        end else if (i_coef_we) begin
            for (int k = 0; k < 9; k++) begin
                if (i_coef_addr == 4'(k)) begin
                    coef[k] <= $signed(i_coef_data);
                end
            end
        end
    end

    // unsigned pixel times signed coefficient
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            prod_c[k] = PW'($signed({1'b0, win[k]})) * PW'(coef[k]);
        end
    end

    // stage 1: register products, shift amount and window flags
    always_ff @(posedge i_clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= i_drdy && win_ok;
            s1_last  <= i_drdy && row_last && col_last;
            if (i_drdy) begin
                prod     <= prod_c;
                s1_shift <= i_shift;
            end
        end
    end

    // full-width sum, arithmetic shift, clamp into pixel range
    always_comb begin
        acc = '0;
        for (int k = 0; k < 9; k++) begin
            acc = acc + SW'(prod[k]);
        end
        shd = acc >>> s1_shift;
        if (shd[SW-1]) begin
            sat = '0;
        end else if (|shd[SW-2:D_BITS]) begin
            sat = '1;
        end else begin
            sat = shd[D_BITS-1:0];
        end
    end

    // stage 2: output register, data held between pulses
    always_ff @(posedge i_clk) begin
        if (reset) begin
            o_dvalid     <= 1'b0;
            o_frame_done <= 1'b0;
            o_data       <= '0;
        end else begin
            o_dvalid     <= s1_valid;
            o_frame_done <= s1_last;
            if (s1_valid) begin
                o_data <= sat;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_stream.sv
// tb_conv3x3_stream: randomized and directed frames against a
// window-arithmetic reference model of the 3x3 valid-mode convolution.
module tb_conv3x3_stream;

    localparam int R = 10;
    localparam int C = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       drdy;
    logic [7:0] din;
    logic       we;
    logic [3:0] caddr;
    logic [7:0] cdata;
    logic [4:0] shift;
    logic       o_dvalid;
    logic [7:0] o_data;
    logic       o_frame_done;

    conv3x3_stream #(
        .row_depth(R),
        .column_depth(C),
        .D_BITS(8),
        .K_BITS(8)
    ) dut (
        .i_clk(clk),
        .reset(reset),
        .i_drdy(drdy),
        .i_data(din),
        .i_coef_we(we),
        .i_coef_addr(caddr),
        .i_coef_data(cdata),
        .i_shift(shift),
        .o_dvalid(o_dvalid),
        .o_data(o_data),
        .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int img [R][C];
    int cur_k [9];
    int exp_val [$];
    int exp_fd [$];
    int exp_cyc [$];
    int got_val [$];
    int got_fd [$];
    int got_cyc [$];
    int fd_stray = 0;
    int hold_err = 0;
    logic [7:0] last_data = '0;
    logic rst_q;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rst_q <= reset;

    always @(negedge clk) begin
        if (o_dvalid === 1'b1) begin
            got_val.push_back(int'(o_data));
            got_fd.push_back(int'(o_frame_done));
            got_cyc.push_back(cyc);
        end
        if (o_frame_done === 1'b1 && o_dvalid !== 1'b1) fd_stray++;
        if (o_dvalid === 1'b0 && rst_q === 1'b0 && o_data !== last_data) hold_err++;
        last_data = o_data;
    end

    function automatic int ref_px(int r, int c, int k[9], int sh);
        longint s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += longint'(img[r-2+i][c-2+j]) * longint'(k[3*i+j]);
        s = s >>> sh;
        if (s < 0) return 0;
        if (s > 255) return 255;
        return int'(s);
    endfunction

    task automatic build_exp(input int nfr, input int wr_at,
                             input int k_old[9], input int k_new[9], input int sh);
        for (int p = 0; p < nfr * R * C; p++) begin
            int r, c;
            r = (p / C) % R;
            c = p % C;
            if (r >= 2 && c >= 2) begin
                exp_val.push_back(ref_px(r, c, (p <= wr_at) ? k_old : k_new, sh));
                exp_fd.push_back((r == R-1 && c == C-1) ? 1 : 0);
            end
        end
    endtask

    task automatic clear_q();
        exp_val.delete(); exp_fd.delete(); exp_cyc.delete();
        got_val.delete(); got_fd.delete(); got_cyc.delete();
    endtask

    task automatic set_coef(input int a, input int v);
        @(negedge clk);
        drdy = 0; we = 1; caddr = 4'(a); cdata = 8'(v);
        @(negedge clk);
        we = 0;
        if (a < 9) cur_k[a] = v;
    endtask

    task automatic drive(input int npix, input int gap, input int wr_at,
                         input int wr_a, input int wr_v, input int sh);
        for (int p = 0; p < npix; p++) begin
            int r, c;
            r = (p / C) % R;
            c = p % C;
            repeat (gap - 1) begin
                @(negedge clk);
                drdy = 0; we = 0;
            end
            @(negedge clk);
            drdy = 1; din = 8'(img[r][c]); shift = 5'(sh);
            we = (p == wr_at); caddr = 4'(wr_a); cdata = 8'(wr_v);
            if (r >= 2 && c >= 2) exp_cyc.push_back(cyc);
        end
        @(negedge clk);
        drdy = 0; we = 0;
    endtask

    task automatic fill_flat(input int v);
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) img[r][c] = v;
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) img[r][c] = 10*r + c;
    endtask

    task automatic test_reset();
        reset = 1; drdy = 1; we = 1; caddr = 4; cdata = 8'd5; din = 8'd77; shift = 0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (o_dvalid !== 1'b0) $display("FAIL rst_dvalid got %b want 0", o_dvalid);
        else n_pass++;
        n_chk++;
        if (o_data !== 8'd0) $display("FAIL rst_data got %0d want 0", o_data);
        else n_pass++;
        n_chk++;
        if (o_frame_done !== 1'b0) $display("FAIL rst_fdone got %b want 0", o_frame_done);
        else n_pass++;
        reset = 0; drdy = 0; we = 0;
        cur_k = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        @(negedge clk);
    endtask

    task automatic test_ramp(input int gap);
        int nfd;
        clear_q();
        fill_ramp();
        drive(R*C, gap, -1, 0, 0, 0);
        repeat (4) @(negedge clk);
        build_exp(1, -1, cur_k, cur_k, 0);
        n_chk++;
        if (got_val.size() !== 64) $display("FAIL ramp_g%0d count got %0d want 64", gap, got_val.size());
        else n_pass++;
        nfd = 0;
        for (int i = 0; i < got_val.size() && i < exp_val.size(); i++) begin
            nfd += got_fd[i];
            n_chk++;
            if (got_val[i] !== exp_val[i] || got_cyc[i] - exp_cyc[i] !== 2 || got_fd[i] !== exp_fd[i])
                $display("FAIL ramp_g%0d out%0d val=%0d want %0d lat=%0d want 2 fd=%0d want %0d",
                         gap, i, got_val[i], exp_val[i], got_cyc[i] - exp_cyc[i], got_fd[i], exp_fd[i]);
            else n_pass++;
        end
        n_chk++;
        if (nfd !== 1) $display("FAIL ramp_g%0d fdone got %0d want 1", gap, nfd);
        else n_pass++;
        n_chk++;
        if (got_val.size() == 0 || got_val[got_val.size()-1] !== 88)
            $display("FAIL ramp_g%0d last got %0d want 88", gap,
                     got_val.size() == 0 ? -1 : got_val[got_val.size()-1]);
        else n_pass++;
    endtask

    task automatic test_flat(input string nm, input int v, input int sh, input int want);
        clear_q();
        fill_flat(v);
        drive(R*C, 1, -1, 0, 0, sh);
        repeat (4) @(negedge clk);
        build_exp(1, -1, cur_k, cur_k, sh);
        n_chk++;
        if (got_val.size() !== 64) $display("FAIL %s count got %0d want 64", nm, got_val.size());
        else n_pass++;
        for (int i = 0; i < got_val.size() && i < exp_val.size(); i++) begin
            n_chk++;
            if (got_val[i] !== exp_val[i] || got_val[i] !== want || got_cyc[i] - exp_cyc[i] !== 2)
                $display("FAIL %s out%0d val=%0d want %0d lat=%0d want 2",
                         nm, i, got_val[i], want, got_cyc[i] - exp_cyc[i]);
            else n_pass++;
        end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 9; k++) set_coef(k, 1);
        test_flat("sat255", 255, 3, 255);
        test_flat("flat16", 16, 3, 18);
    endtask

    task automatic test_negative();
        for (int k = 0; k < 9; k++) set_coef(k, 0);
        set_coef(4, -1);
        test_flat("neg_clamp", 100, 0, 0);
        for (int k = 0; k < 9; k++) set_coef(k, -1);
        set_coef(4, 8);
        test_flat("laplace", 100, 0, 0);
    endtask

    task automatic test_random(input int gap);
        int sh;
        clear_q();
        set_coef(12, 99);
        for (int k = 0; k < 9; k++) set_coef(k, int'($urandom_range(0, 255)) - 128);
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) img[r][c] = int'($urandom_range(0, 255));
        sh = int'($urandom_range(4, 10));
        drive(R*C, gap, -1, 0, 0, sh);
        repeat (4) @(negedge clk);
        build_exp(1, -1, cur_k, cur_k, sh);
        n_chk++;
        if (got_val.size() !== 64) $display("FAIL rand_g%0d count got %0d want 64", gap, got_val.size());
        else n_pass++;
        for (int i = 0; i < got_val.size() && i < exp_val.size(); i++) begin
            n_chk++;
            if (got_val[i] !== exp_val[i] || got_cyc[i] - exp_cyc[i] !== 2 || got_fd[i] !== exp_fd[i])
                $display("FAIL rand_g%0d out%0d val=%0d want %0d lat=%0d want 2 fd=%0d want %0d",
                         gap, i, got_val[i], exp_val[i], got_cyc[i] - exp_cyc[i], got_fd[i], exp_fd[i]);
            else n_pass++;
        end
    endtask

    task automatic test_coef_switch();
        int k_old [9];
        int k_new [9];
        int a, v, sh, nfd;
        clear_q();
        for (int k = 0; k < 9; k++) set_coef(k, int'($urandom_range(0, 200)) - 100);
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) img[r][c] = int'($urandom_range(0, 255));
        k_old = cur_k;
        a = int'($urandom_range(0, 8));
        v = (k_old[a] >= 0) ? k_old[a] - 60 : k_old[a] + 60;
        k_new = k_old;
        k_new[a] = v;
        sh = 6;
        drive(2*R*C, 1, 5*C + 5, a, v, sh);
        cur_k = k_new;
        repeat (4) @(negedge clk);
        build_exp(2, 5*C + 5, k_old, k_new, sh);
        n_chk++;
        if (got_val.size() !== 128) $display("FAIL coef_sw count got %0d want 128", got_val.size());
        else n_pass++;
        nfd = 0;
        for (int i = 0; i < got_val.size() && i < exp_val.size(); i++) begin
            nfd += got_fd[i];
            n_chk++;
            if (got_val[i] !== exp_val[i] || got_cyc[i] - exp_cyc[i] !== 2 || got_fd[i] !== exp_fd[i])
                $display("FAIL coef_sw out%0d val=%0d want %0d lat=%0d want 2 fd=%0d want %0d",
                         i, got_val[i], exp_val[i], got_cyc[i] - exp_cyc[i], got_fd[i], exp_fd[i]);
            else n_pass++;
        end
        n_chk++;
        if (nfd !== 2) $display("FAIL coef_sw fdone got %0d want 2", nfd);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        int rst_cyc, late, nfd;
        clear_q();
        fill_ramp();
        drive(45, 1, -1, 0, 0, 0);
        reset = 1;
        rst_cyc = cyc;
        drdy = 1; we = 1; caddr = 4'd0; cdata = 8'd7;
        repeat (2) @(negedge clk);
        reset = 0; drdy = 0; we = 0;
        cur_k = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        late = 0;
        for (int i = 0; i < got_cyc.size(); i++) if (got_cyc[i] > rst_cyc) late++;
        n_chk++;
        if (late !== 0) $display("FAIL midrst late_outputs got %0d want 0", late);
        else n_pass++;
        @(negedge clk);
        clear_q();
        drive(R*C, 1, -1, 0, 0, 0);
        repeat (4) @(negedge clk);
        build_exp(1, -1, cur_k, cur_k, 0);
        n_chk++;
        if (got_val.size() !== 64) $display("FAIL midrst count got %0d want 64", got_val.size());
        else n_pass++;
        nfd = 0;
        for (int i = 0; i < got_val.size() && i < exp_val.size(); i++) begin
            nfd += got_fd[i];
            n_chk++;
            if (got_val[i] !== exp_val[i] || got_cyc[i] - exp_cyc[i] !== 2)
                $display("FAIL midrst out%0d val=%0d want %0d lat=%0d want 2",
                         i, got_val[i], exp_val[i], got_cyc[i] - exp_cyc[i]);
            else n_pass++;
        end
        n_chk++;
        if (nfd !== 1) $display("FAIL midrst fdone got %0d want 1", nfd);
        else n_pass++;
        n_chk++;
        if (fd_stray !== 0) $display("FAIL fdone_alone got %0d want 0", fd_stray);
        else n_pass++;
        n_chk++;
        if (hold_err !== 0) $display("FAIL data_hold changes got %0d want 0", hold_err);
        else n_pass++;
    endtask

    initial begin
        reset = 1; drdy = 0; we = 0; din = 0; caddr = 0; cdata = 0; shift = 0;
        test_reset();
        test_ramp(1);
        test_ramp(17);
        test_saturate();
        test_negative();
        test_random(1);
        test_random(3);
        test_coef_switch();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/conv3x3_stream.md
CONV3X3_STREAM -- requirements
Module: conv3x3_stream

Interface
REQ-001 SHALL have parameter row_depth, default 10, frame height in pixels (>=3).
REQ-002 SHALL have parameter column_depth, default 10, frame width in pixels (>=3).
REQ-003 SHALL have parameter D_BITS, default 8, unsigned pixel width.
REQ-004 SHALL have parameter K_BITS, default 8, signed two's-complement coefficient width.
REQ-005 SHALL have port i_clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port i_drdy  input  1  input pixel valid, one pixel accepted per high cycle.
REQ-008 SHALL have port i_data  input  D_BITS  pixel, raster order, row-major.
REQ-009 SHALL have port i_coef_we  input  1  coefficient write strobe.
REQ-010 SHALL have port i_coef_addr  input  4  coefficient index 0..8, row-major (0 = top-left, 4 = centre); 9..15 ignored.
REQ-011 SHALL have port i_coef_data  input  K_BITS  coefficient value.
REQ-012 SHALL have port i_shift  input  5  arithmetic right-shift applied to each window sum.
REQ-013 SHALL have port o_dvalid  output  1  one-cycle pulse per output pixel.
REQ-014 SHALL have port o_data  output  D_BITS  filtered pixel.
REQ-015 SHALL have port o_frame_done  output  1  one-cycle pulse coincident with last output of a frame.

Function
REQ-016 SHALL keep column counter (0..column_depth-1) and row counter (0..row_depth-1), advanced only on i_drdy; column wraps to 0 and increments row; row wraps to 0 after last pixel of frame, next pixel starts new frame.
REQ-017 SHALL hold two line buffers of column_depth entries each plus a 3x3 window register set, one pixel per cycle sustained (i_drdy may be high every cycle or with arbitrary gaps).
REQ-018 SHALL produce output only for valid-mode windows: pixel accepted at (row r, col c) with r>=2 and c>=2 yields window centred on (r-1, c-1); (row_depth-2)*(column_depth-2) outputs per frame.
REQ-019 SHALL assert o_dvalid exactly 2 cycles after the i_drdy cycle that completes a window (stage 1: 9 products; stage 2: sum, shift, saturate), pipelined, independent of input gaps.
REQ-020 SHALL compute products as unsigned pixel x signed coefficient, signed sum at full width (D_BITS+K_BITS+5 bits), no intermediate overflow.
REQ-021 SHALL arithmetic-right-shift the sum by i_shift sampled in the accepting cycle, then saturate to 0..2^D_BITS-1 (negative -> 0, over-range -> all ones).
REQ-022 SHALL write i_coef_data to coefficient i_coef_addr on i_coef_we; a pixel accepted in the same cycle as a write SHALL use old coefficients; pixels accepted later use new values.
REQ-023 SHALL hold o_data at last value when o_dvalid is low.
REQ-024 SHALL pulse o_frame_done together with o_dvalid for window completed by pixel (row_depth-1, column_depth-1), and never otherwise.
REQ-025 SHALL ignore line-buffer contents from a previous frame: no output for r<2 or c<2 in any frame.

Reset
REQ-026 SHALL, while reset is high, clear row/column counters, pipeline valids, o_dvalid=0, o_data=0, o_frame_done=0; i_drdy and i_coef_we ignored.
REQ-027 SHALL on reset load coefficients to identity: index 4 = 1, all others 0.
REQ-028 SHALL on reset mid-frame discard in-flight pipeline results (no o_dvalid after the reset cycle) and restart at pixel (0,0); line-buffer RAM contents need not be cleared.

Verification
REQ-029 SHALL cover: reset defaults, 10x10 ramp pixel=10*r+c, back-to-back i_drdy, shift 0 -> 64 outputs equal 10*(r-1)+(c-1) for r,c=2..9, each 2 cycles after its input, o_frame_done with value 88.
REQ-030 SHALL cover: all coefficients 1, shift 3, flat image 255 -> every output 255 (2295>>3=286 saturated); flat 16 -> 18.
REQ-031 SHALL cover: coefficient 4 = -1, others 0, flat 100 -> all outputs 0 (negative clamp); Laplacian (centre 8, others -1) flat 100 -> 0.
REQ-032 SHALL cover: same ramp frame with i_drdy pulsed once every 17 cycles -> identical output sequence to back-to-back, each output 2 cycles after completing pixel.
REQ-033 SHALL cover: reset asserted after pixel 45 of a frame -> no o_dvalid after reset; new full frame then yields exactly 64 outputs and one o_frame_done.
REQ-034 SHALL cover: coefficient write coincident with pixel (5,5) -> that window uses old kernel, window from (5,6) uses new kernel; two consecutive frames give 128 outputs, 2 o_frame_done pulses.
